// File: rtl/npc_seq_if.sv
// Controller-side bundle for the multi-cycle next-PC sequencer: instruction and
// data memory handshakes, the next-PC datapath value, and the controller outputs.
interface npc_seq_if;
  logic [31:0] instr;
  logic        im_ready;
  logic        dm_ready;
  logic [1:0]  com;
  logic [31:0] npc_in;
  logic [31:0] pc;
  logic [2:0]  npc_sel;
  logic        pc_we;
  logic        ir_we;
  logic        rf_we;
  logic        dm_we;
  logic [2:0]  state;
  logic [31:0] retired;

  modport master (
    input  instr, im_ready, dm_ready, com, npc_in,
    output pc, npc_sel, pc_we, ir_we, rf_we, dm_we, state, retired
  );

  modport slave (
    output instr, im_ready, dm_ready, com, npc_in,
    input  pc, npc_sel, pc_we, ir_we, rf_we, dm_we, state, retired
  );
endinterface

// File: rtl/npc_seq.sv
// Multi-cycle MIPS-subset sequencer: owns the PC, the latched instruction word
// and the retired-instruction count, and issues single-cycle write enables.
//
// state  | meaning
// FETCH  | wait for im_ready, latch instr into ir_q
// DECODE | opcode/funct from ir_q settle, no enables
// EXEC   | branch/jump/skip retire here; lw/sw go to MEM; ALU ops go to WB
// MEM    | hold until dm_ready; sw retires here, lw continues to WB
// WB     | register-file write and PC advance
module npc_seq (
  input  logic       clk,
  input  logic       reset,
  npc_seq_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] SEL_PC4    = 3'b000;
  localparam logic [2:0] SEL_BRANCH = 3'b001;
  localparam logic [2:0] SEL_JUMP   = 3'b010;
  localparam logic [2:0] SEL_REG    = 3'b011;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;

  logic [5:0] op, funct;
  logic       is_beq, is_jump, is_jal, is_jr, is_mem, is_sw, is_alu;

  logic [2:0] npc_sel_c;
  logic       pc_we_c, ir_we_c, rf_we_c, dm_we_c;

  assign op    = ir_q[31:26];
  assign funct = ir_q[5:0];

  assign is_beq  = (op == OP_BEQ);
  assign is_jal  = (op == OP_JAL);
  assign is_jump = (op == OP_J) || is_jal;
  assign is_jr   = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_sw   = (op == OP_SW);
  assign is_mem  = (op == OP_LW) || is_sw;
  // An all-zero word is a nop routed through WB; other funct=0 R-types are skipped.
  assign is_alu  = ((op == OP_RTYPE) && ((funct == FN_ADDU) || (funct == FN_SUBU)))
                || (op == OP_ORI) || (op == OP_LUI) || (ir_q == 32'h0);

  always_comb begin
    state_d   = FETCH;
    npc_sel_c = SEL_PC4;
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    rf_we_c   = 1'b0;
    dm_we_c   = 1'b0;
    case (state_q)
      FETCH: begin
        ir_we_c = bus.im_ready;
        state_d = bus.im_ready ? DECODE : FETCH;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (is_beq) begin
          npc_sel_c = SEL_BRANCH;
          pc_we_c   = 1'b1;
        end else if (is_jump) begin
          npc_sel_c = SEL_JUMP;
          pc_we_c   = 1'b1;
          rf_we_c   = is_jal;
        end else if (is_jr) begin
          npc_sel_c = SEL_REG;
          pc_we_c   = 1'b1;
        end else if (is_mem) begin
          state_d = MEM;
        end else if (is_alu) begin
          state_d = WB;
        end else begin
          pc_we_c = 1'b1;
        end
      end
      MEM: begin
        if (!bus.dm_ready) begin
          state_d = MEM;
        end else if (is_sw) begin
          dm_we_c = 1'b1;
          pc_we_c = 1'b1;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset masks every enable so an abandoned instruction never writes or retires.
  assign bus.npc_sel = reset ? SEL_PC4 : npc_sel_c;
  assign bus.pc_we   = pc_we_c & ~reset;
  assign bus.ir_we   = ir_we_c & ~reset;
  assign bus.rf_we   = rf_we_c & ~reset;
  assign bus.dm_we   = dm_we_c & ~reset;

  assign ir_d      = bus.ir_we ? bus.instr : ir_q;
  assign pc_d      = bus.pc_we ? bus.npc_in : pc_q;
  assign retired_d = bus.pc_we ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      ir_q      <= 32'h0;
      pc_q      <= PC_RESET;
      retired_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_npc_seq.sv
// Self-checking bench for npc_seq: table of instructions with expected enables,
// state traces and latencies, scored through an expected-result queue.
module tb_npc_seq;

  logic clk;
  logic reset;
  npc_seq_if bus ();

  npc_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          im_wait;
    int          dm_wait;
    logic [31:0] npc;
    logic [2:0]  sel;
    int          rf_n;
    int          dm_n;
    int          cycles;
    logic [31:0] trace;
  } vec_t;

  typedef struct {
    logic [2:0]  sel;
    int          rf_n;
    int          dm_n;
    int          cycles;
    logic [31:0] trace;
    logic [31:0] pc;
    logic [31:0] retired;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[15];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] ret_model = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Entered and left just after a falling edge.
  task automatic run_vec(input vec_t v, input string nm);
    exp_t        e;
    int          im_cnt, dm_cnt, cyc, rf_n, dm_n, ir_n, bad_sel;
    logic [31:0] trace;
    logic [2:0]  sel_seen;
    logic        done;
    e = '{v.sel, v.rf_n, v.dm_n, v.cycles, v.trace, v.npc, ret_model + 32'd1};
    sb_q.push_back(e);
    bus.instr    = v.instr;
    bus.npc_in   = v.npc;
    bus.im_ready = (v.im_wait == 0);
    bus.dm_ready = (v.dm_wait == 0);
    im_cnt = 0; dm_cnt = 0; cyc = 0; rf_n = 0; dm_n = 0; ir_n = 0; bad_sel = 0;
    trace = 32'h0; sel_seen = 3'd0; done = 1'b0;
    while (!done && cyc < 40) begin
      #1;
      cyc++;
      trace = {trace[27:0], 1'b0, bus.state};
      if (bus.ir_we) ir_n++;
      if (bus.rf_we) rf_n++;
      if (bus.dm_we) dm_n++;
      if (bus.state == 3'd0 && !bus.im_ready) im_cnt++;
      if (bus.state == 3'd3 && !bus.dm_ready) dm_cnt++;
      if (bus.pc_we) begin
        done = 1'b1;
        sel_seen = bus.npc_sel;
      end else if (bus.npc_sel != 3'd0) begin
        bad_sel++;
      end
      @(negedge clk);
      bus.im_ready = (im_cnt >= v.im_wait);
      bus.dm_ready = (dm_cnt >= v.dm_wait);
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s timeout: no pc_we within %0d cycles, expected %0d", nm, cyc, v.cycles);
      void'(sb_q.pop_front());
    end else begin
      ret_model = ret_model + 32'd1;
      e = sb_q.pop_front();
      check({nm, " cycles"},  cyc,      e.cycles);
      check({nm, " trace"},   trace,    e.trace);
      check({nm, " npc_sel"}, sel_seen, e.sel);
      check({nm, " idle_sel"}, bad_sel, 0);
      check({nm, " rf_we"},   rf_n,     e.rf_n);
      check({nm, " dm_we"},   dm_n,     e.dm_n);
      check({nm, " ir_we"},   ir_n,     1);
      check({nm, " pc"},      bus.pc,   e.pc);
      check({nm, " retired"}, bus.retired, e.retired);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input string nm, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus.state == st) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s timeout waiting for state %0d, got %0d", nm, st, bus.state);
    end
  endtask

  task automatic mid_reset(input logic [31:0] ins, input logic dmr, input string nm);
    logic ok;
    bus.instr    = ins;
    bus.npc_in   = 32'h0000_4000;
    bus.im_ready = 1'b1;
    bus.dm_ready = dmr;
    @(negedge clk);
    wait_state(3'd3, nm, ok);
    if (ok) begin
      if (!dmr) begin
        @(negedge clk);
        #1;
        check({nm, " mem_hold"}, bus.state, 3'd3);
      end
      reset = 1'b1;
      #1;
      check({nm, " rst pc_we"}, bus.pc_we, 1'b0);
      check({nm, " rst rf_we"}, bus.rf_we, 1'b0);
      check({nm, " rst dm_we"}, bus.dm_we, 1'b0);
      @(negedge clk);
      check({nm, " state"},   bus.state,   3'd0);
      check({nm, " pc"},      bus.pc,      32'h0000_3000);
      check({nm, " retired"}, bus.retired, 32'h0);
      ret_model = 32'h0;
    end
    reset = 1'b0;
    bus.dm_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             instr        imw dmw npc          sel  rf dm cyc trace
    vecs[0]  = '{32'h00851021, 0, 0, 32'h00003004, 3'd0, 1, 0, 4, 32'h00000124};
    vecs[1]  = '{32'h00851021, 3, 0, 32'h00003008, 3'd0, 1, 0, 7, 32'h00000124};
    vecs[2]  = '{32'hAC450004, 0, 2, 32'h0000300C, 3'd0, 0, 1, 6, 32'h00012333};
    vecs[3]  = '{32'h8C450004, 0, 0, 32'h00003010, 3'd0, 1, 0, 5, 32'h00001234};
    vecs[4]  = '{32'h10850003, 0, 0, 32'h00003020, 3'd1, 0, 0, 3, 32'h00000012};
    vecs[5]  = '{32'h0C000C04, 0, 0, 32'h00003010, 3'd2, 1, 0, 3, 32'h00000012};
    vecs[6]  = '{32'h03E00008, 0, 0, 32'h00003040, 3'd3, 0, 0, 3, 32'h00000012};
    vecs[7]  = '{32'h08000C00, 0, 0, 32'h00003000, 3'd2, 0, 0, 3, 32'h00000012};
    vecs[8]  = '{32'hFC000000, 0, 0, 32'h00003004, 3'd0, 0, 0, 3, 32'h00000012};
    vecs[9]  = '{32'h00000000, 0, 0, 32'h00003008, 3'd0, 1, 0, 4, 32'h00000124};
    vecs[10] = '{32'h34A50001, 0, 0, 32'h0000300C, 3'd0, 1, 0, 4, 32'h00000124};
    vecs[11] = '{32'h3C051234, 0, 0, 32'h00003010, 3'd0, 1, 0, 4, 32'h00000124};
    vecs[12] = '{32'h00851023, 0, 0, 32'h00003014, 3'd0, 1, 0, 4, 32'h00000124};
    vecs[13] = '{32'h00041080, 0, 0, 32'h00003018, 3'd0, 0, 0, 3, 32'h00000012};
    vecs[14] = '{32'h8C450008, 0, 1, 32'h0000301C, 3'd0, 1, 0, 6, 32'h00012334};

    reset        = 1'b1;
    bus.instr    = 32'h0;
    bus.im_ready = 1'b1;
    bus.dm_ready = 1'b1;
    bus.com      = 2'b00;
    bus.npc_in   = 32'h0000_1234;
    @(negedge clk);
    #1;
    check("reset ir_we", bus.ir_we, 1'b0);
    check("reset pc_we", bus.pc_we, 1'b0);
    @(negedge clk);
    check("reset state",   bus.state,   3'd0);
    check("reset pc",      bus.pc,      32'h0000_3000);
    check("reset retired", bus.retired, 32'h0);
    check("reset npc_sel", bus.npc_sel, 3'd0);
    check("reset rf_we",   bus.rf_we,   1'b0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (i == 4) bus.com = 2'b01;
      else bus.com = 2'b00;
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    mid_reset(32'h8C450004, 1'b0, "rst_lw_mem");
    mid_reset(32'hAC450004, 1'b1, "rst_sw_mem");
    run_vec(vecs[0], "post_reset_addu");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/npc_seq.md
NPC_SEQ -- requirements
Module: npc_seq

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 instr  input  32  instruction word from instruction memory at address pc.
REQ-004 im_ready  input  1  instruction memory handshake; instr valid when high.
REQ-005 dm_ready  input  1  data memory handshake; access completes when high.
REQ-006 com  input  2  comparator result for beq; 2'b00 = operands equal (branch taken).
REQ-007 npc_in  input  32  next-PC value from the next-PC adder, already resolved for npc_sel.
REQ-008 pc  output  32  current PC register.
REQ-009 npc_sel  output  3  next-PC select: 000 PC+4, 001 branch, 010 jump (j/jal), 011 register (jr).
REQ-010 pc_we, ir_we, rf_we, dm_we  output  1 each  write enables for PC, instruction register, register file, data memory.
REQ-011 state  output  3  current FSM state encoding (debug/verification).
REQ-012 retired  output  32  retired-instruction counter.

Function
REQ-013 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL return to FETCH next cycle with no enables asserted.
REQ-014 FETCH: ir_we = im_ready; stay in FETCH while im_ready=0; go DECODE when im_ready=1.
REQ-015 DECODE: no enables; unconditionally to EXEC; opcode/funct latched from instr captured in FETCH.
REQ-016 EXEC, beq (op 000100): npc_sel=001, pc_we=1, -> FETCH; npc_in reflects taken/not-taken per com, controller does not gate on com.
REQ-017 EXEC, j (000010): npc_sel=010, pc_we=1, -> FETCH; jal (000011): same plus rf_we=1 (link write) in the same cycle.
REQ-018 EXEC, jr (op 000000, funct 001000): npc_sel=011, pc_we=1, rf_we=0, -> FETCH.
REQ-019 EXEC, lw (100011) / sw (101011): -> MEM, no enables.
REQ-020 EXEC, addu (000000/100001), subu (000000/100011), ori (001101), lui (001111), all-zero word (nop): -> WB, no enables.
REQ-021 EXEC, any other opcode/funct: npc_sel=000, pc_we=1, no other enables, -> FETCH (skipped, counted as retired).
REQ-022 MEM: hold while dm_ready=0 with no enables; on dm_ready=1: sw asserts dm_we=1, npc_sel=000, pc_we=1, -> FETCH; lw -> WB without dm_we.
REQ-023 WB: rf_we=1, npc_sel=000, pc_we=1, -> FETCH.
REQ-024 npc_sel SHALL be 000 in every cycle not listed above; all enables are combinational from state and latched instruction, single-cycle pulses.
REQ-025 pc SHALL load npc_in on the rising edge where pc_we=1, otherwise hold.
REQ-026 retired SHALL increment by 1 on every pc_we=1 edge; wraps 0xFFFFFFFF -> 0x00000000.
REQ-027 Latency: ALU 4 cycles, lw 5, sw 4, branch/jump 3, each plus FETCH/MEM wait cycles.
REQ-028 dm_we, rf_we, pc_we SHALL never be asserted in the same cycle as reset=1.

Reset
REQ-029 On reset: state=FETCH, pc=0x00003000, retired=0, latched instruction=0, all enables 0, npc_sel=000.
REQ-030 Reset mid-instruction (any state, including MEM wait) SHALL abandon it with no write issued and no counter increment.

Verification
REQ-031 Reset, im_ready=1, instr=addu -> states 0,1,2,4,0; rf_we pulse in WB; pc 0x3000 -> npc_in; retired=1.
REQ-032 im_ready held 0 for 3 cycles then 1 -> 3 extra FETCH cycles, ir_we only in the im_ready=1 cycle.
REQ-033 sw with dm_ready=0 for 2 cycles -> MEM held 3 cycles, single dm_we and pc_we pulse on dm_ready=1, npc_sel=000.
REQ-034 beq, jal, jr each -> EXEC npc_sel 001/010/011 with pc_we=1; jal also rf_we=1; pc loads npc_in (e.g. 0x00003010).
REQ-035 Undefined opcode 111111 -> EXEC pc_we=1, npc_sel=000, no rf_we/dm_we; retired increments.
REQ-036 Assert reset in MEM during lw -> next cycle state=FETCH, pc=0x00003000, retired=0, no rf_we.
